cbfp1_pair_buffer: RTL and testbench
====================================

# cbfp1_pair_buffer

Consumes the 16-lane block-floating-point stream produced by the first CBFP normalisation stage (12-bit re/im per lane plus a 5-bit per-lane scaling index). It buffers groups of `DIST` accepted input beats and pairs each one with the beat arriving `DIST` beats later. Both beats are presented together so the next radix-2 butterfly stage receives its `x[n]` and `x[n+DIST]` operands in the same cycle. It sits directly between the CBFP1 stage and the stage-2 butterfly.

## Interface
Parameters:
- `DW`, 12: data width per re/im sample (signed <6.6>).
- `IW`, 5: scaling-index width per lane.
- `NCHAN`, 16: parallel lanes per beat.
- `DIST`, 4: pairing distance in accepted beats; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `valid_in`, in, 1: input beat valid.
- `sof_in`, in, 1: first beat of a frame; qualified by `valid_in`.
- `data_re_in[NCHAN]`, in, signed `DW` each: real samples.
- `data_im_in[NCHAN]`, in, signed `DW` each: imaginary samples.
- `idx_in[NCHAN]`, in, `IW` each: per-lane scaling index.
- `a_re[NCHAN]`, `a_im[NCHAN]`, out, signed `DW` each: earlier operand, beat n.
- `b_re[NCHAN]`, `b_im[NCHAN]`, out, signed `DW` each: later operand, beat n+DIST.
- `a_idx[NCHAN]`, `b_idx[NCHAN]`, out, `IW` each: scaling indices travelling with a and b.
- `pair_pos`, out, `$clog2(DIST)`: position of the pair within its group, 0..DIST-1.
- `sof_out`, out, 1: marks the first pair emitted after a frame start.
- `valid_out`, out, 1: output pair valid.

## Operation
- A beat counter `cnt` (`$clog2(DIST)+1` bits, range 0..2·DIST-1) advances only on accepted beats (`valid_in`=1). It wraps 2·DIST-1 → 0.
- The MSB of `cnt` selects the phase: FILL for `cnt` < DIST, PAIR for `cnt` ≥ DIST. There is no other state.
- FILL beat: write `{re, im, idx}` of all lanes into buffer entry `cnt`. No output.
- PAIR beat:
  - Read buffer entry `cnt-DIST` into `a_*`.
  - Register the current input into `b_*`.
  - Set `pair_pos` ← `cnt-DIST`.
  - Set `valid_out` ← 1.
- Buffer: DIST entries × NCHAN × (2·DW+IW) bits, registers or a simple dual-port array. No arithmetic is performed; all bits pass through unchanged. The idx signal is not interpreted.
- `sof_in`=1 with `valid_in`=1: the beat is forced to `cnt`=0 (written to entry 0), and `cnt` becomes 1.
  - Any partially filled or partially paired group is abandoned. No output is produced for the abandoned remainder.
  - An internal `sof_pending` flag is set. It is cleared when the next PAIR beat is emitted, and that pair drives `sof_out`=1.
- `sof_in` with `valid_in`=0 is ignored.
- Before the first `sof_in` after reset, the block pairs from `cnt`=0 normally, and `sof_out` stays 0.

## Timing
- Latency: a PAIR-phase input beat on cycle t produces `valid_out`=1 on cycle t+1, with `b_*` equal to that beat.
- `valid_out` is high for exactly one cycle per PAIR-phase accepted beat. There is no backpressure, so the downstream stage must accept every pair.
- When `valid_out`=0, all data, idx, `pair_pos` and `sof_out` outputs hold their last values. `sof_out` is additionally forced to 0.
- Gaps (`valid_in`=0) may occur in either phase. Buffered entries are retained indefinitely, and `cnt` does not advance.
- Reset (asserted at any time, including mid-group):
  - `cnt`=0 and `sof_pending`=0.
  - All outputs are 0: `valid_out`, `sof_out`, `pair_pos`, every `a_*` and `b_*` lane.
  - Buffer contents need not be cleared.
  - The first beat after reset deassertion is treated as `cnt`=0.
- Simultaneous events:
  - PAIR beat with `sof_in`=1: the `sof_in` wins. The beat is written as FILL entry 0 and no pair is emitted that cycle.
  - A write and a read of the same entry cannot occur in one cycle, because phases are exclusive.

## Test plan
- Ramp, DIST=4:
  - Stimulus: 8 consecutive beats, lane k of beat n has re=16n+k, im=-(16n+k), idx=n; `sof_in` on beat 0.
  - Required: 4 outputs on cycles 5..8. Pair j has a_re[k]=16j+k and b_re[k]=16(j+4)+k. a_idx=j, b_idx=j+4. `pair_pos`=0,1,2,3. `sof_out` only on the first pair.
- Gapped input:
  - Stimulus: same data with `valid_in` toggling 1,0,1,0,…
  - Required: identical pair contents. Each `valid_out` pulse follows its PAIR beat by one cycle. Outputs hold between pulses.
- Resync:
  - Stimulus: `sof_in` on beat 0, then a second `sof_in` on beat 6, followed by 7 more beats.
  - Required: only pairs 0 and 1 from the first group. The new group pairs its beat 0 with its beat 4, with `sof_out`=1 on that pair.
- Reset mid-group:
  - Stimulus: assert `rst` after 5 beats, release, then send 8 beats.
  - Required: all outputs read 0 during reset. The next pair is the new beat 0 with new beat 4. No stale pairs.
- Extremes and back-to-back:
  - Stimulus: 16 continuous beats carrying re=+2047/-2048 and idx=31.
  - Required: bit-exact pass-through. Pairs appear on 8 cycles in two bursts of 4. `cnt` wraps cleanly, with no `valid_out` during FILL.

Source files
------------

// File: rtl/cbfp1_pair_buffer.sv
// cbfp1_pair_buffer: pairs each accepted CBFP1 beat with the one arriving
// DIST accepted beats later, so the stage-2 butterfly receives x[n] and
// x[n+DIST] together. Data and scaling indices pass through untouched.
module cbfp1_pair_buffer #(
    parameter int DW    = 12,
    parameter int IW    = 5,
    parameter int NCHAN = 16,
    parameter int DIST  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic                        sof_in,
    input  logic signed [DW-1:0]        data_re_in [NCHAN],
    input  logic signed [DW-1:0]        data_im_in [NCHAN],
    input  logic        [IW-1:0]        idx_in     [NCHAN],
    output logic signed [DW-1:0]        a_re       [NCHAN],
    output logic signed [DW-1:0]        a_im       [NCHAN],
    output logic signed [DW-1:0]        b_re       [NCHAN],
    output logic signed [DW-1:0]        b_im       [NCHAN],
    output logic        [IW-1:0]        a_idx      [NCHAN],
    output logic        [IW-1:0]        b_idx      [NCHAN],
    output logic [$clog2(DIST)-1:0]     pair_pos,
    output logic                        sof_out,
    output logic                        valid_out
);

    localparam int PW = $clog2(DIST);      // entry address / pair position width
    localparam int CW = PW + 1;            // beat counter: MSB is the phase bit
    localparam int EW = 2 * DW + IW;       // one lane {re, im, idx}
    localparam int BW = NCHAN * EW;        // one whole beat

    logic [BW-1:0] in_word;
    logic [BW-1:0] rd_word;
    logic [BW-1:0] buf_mem [DIST];

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sof_pending_q, sof_pending_d;
    logic [BW-1:0] a_word_q, a_word_d;
    logic [BW-1:0] b_word_q, b_word_d;
    logic [PW-1:0] pair_pos_q, pair_pos_d;
    logic          sof_out_q, sof_out_d;
    logic          valid_out_q, valid_out_d;

    logic          sof_beat;
    logic          pair_phase;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic          emit;

    // Lane packing/unpacking between port arrays and flat beat words
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_lane
        assign in_word[gi*EW +: EW] = {data_re_in[gi], data_im_in[gi], idx_in[gi]};
        assign a_re[gi]  = a_word_q[gi*EW + IW + DW +: DW];
        assign a_im[gi]  = a_word_q[gi*EW + IW      +: DW];
        assign a_idx[gi] = a_word_q[gi*EW           +: IW];
        assign b_re[gi]  = b_word_q[gi*EW + IW + DW +: DW];
        assign b_im[gi]  = b_word_q[gi*EW + IW      +: DW];
        assign b_idx[gi] = b_word_q[gi*EW           +: IW];
    end

    assign pair_pos  = pair_pos_q;
    assign sof_out   = sof_out_q;
    assign valid_out = valid_out_q;

    // Phase decode: a qualified sof always restarts the group as a FILL write
    // to entry 0, even when the counter is in the PAIR half.
    assign sof_beat   = valid_in & sof_in;
    assign pair_phase = cnt_q[CW-1];
    assign wr_en      = valid_in & (sof_beat | ~pair_phase);
    assign wr_addr    = sof_beat ? '0 : cnt_q[PW-1:0];
    assign emit       = valid_in & ~sof_beat & pair_phase;

    // In PAIR phase cnt-DIST is just the low bits, since DIST is a power of two
    assign rd_word = buf_mem[cnt_q[PW-1:0]];

    // Beat buffer: written only in FILL, read only in PAIR, contents never cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= in_word;
        end
    end

    // Next-state: counter, sof tracking and output pair capture
    always_comb begin
        cnt_d         = cnt_q;
        sof_pending_d = sof_pending_q;
        a_word_d      = a_word_q;
        b_word_d      = b_word_q;
        pair_pos_d    = pair_pos_q;
        sof_out_d     = 1'b0;
        valid_out_d   = 1'b0;

        if (sof_beat) begin
            cnt_d         = CW'(1);
            sof_pending_d = 1'b1;
        end else if (valid_in) begin
            cnt_d = cnt_q + 1'b1;          // wraps 2*DIST-1 -> 0
        end

        if (emit) begin
            a_word_d      = rd_word;
            b_word_d      = in_word;
            pair_pos_d    = cnt_q[PW-1:0];
            sof_out_d     = sof_pending_q;
            valid_out_d   = 1'b1;
            sof_pending_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            sof_pending_q <= 1'b0;
            a_word_q      <= '0;
            b_word_q      <= '0;
            pair_pos_q    <= '0;
            sof_out_q     <= 1'b0;
            valid_out_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            sof_pending_q <= sof_pending_d;
            a_word_q      <= a_word_d;
            b_word_q      <= b_word_d;
            pair_pos_q    <= pair_pos_d;
            sof_out_q     <= sof_out_d;
            valid_out_q   <= valid_out_d;
        end
    end

endmodule

// File: tb/tb_cbfp1_pair_buffer.sv
// Directed bench for cbfp1_pair_buffer with an expected-pair scoreboard.
module tb_cbfp1_pair_buffer;

    localparam int DW    = 12;
    localparam int IW    = 5;
    localparam int NCHAN = 16;
    localparam int DIST  = 4;
    localparam int PW    = $clog2(DIST);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic sof_in = 1'b0;
    logic signed [DW-1:0] data_re_in [NCHAN];
    logic signed [DW-1:0] data_im_in [NCHAN];
    logic        [IW-1:0] idx_in     [NCHAN];
    logic signed [DW-1:0] a_re [NCHAN];
    logic signed [DW-1:0] a_im [NCHAN];
    logic signed [DW-1:0] b_re [NCHAN];
    logic signed [DW-1:0] b_im [NCHAN];
    logic        [IW-1:0] a_idx [NCHAN];
    logic        [IW-1:0] b_idx [NCHAN];
    logic [PW-1:0] pair_pos;
    logic          sof_out;
    logic          valid_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int a_id;
        int b_id;
        int pos;
        bit sof;
        int cyc;
    } exp_t;
    exp_t q[$];

    // Last expected pair contents (-1 means the reset zeros)
    int snap_a = -1;
    int snap_b = -1;
    int snap_pos = 0;

    cbfp1_pair_buffer #(.DW(DW), .IW(IW), .NCHAN(NCHAN), .DIST(DIST)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sof_in(sof_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in), .idx_in(idx_in),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .a_idx(a_idx), .b_idx(b_idx), .pair_pos(pair_pos),
        .sof_out(sof_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat content by id: ramp for small ids, full-scale pattern for ids >= 64
    function automatic logic signed [DW-1:0] f_re(int id, int k);
        if (id < 0) return '0;
        if (id >= 64) return ((((id >> 2) + k) & 1) != 0) ? 12'sd2047 : -12'sd2048;
        return DW'(16 * id + k);
    endfunction

    function automatic logic signed [DW-1:0] f_im(int id, int k);
        if (id < 0) return '0;
        if (id >= 64) return ~f_re(id, k);
        return DW'(-(16 * id + k));
    endfunction

    function automatic logic [IW-1:0] f_idx(int id);
        if (id < 0) return '0;
        if (id >= 64) return 5'd31;
        return IW'(id % 32);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(int id, bit sof, bit valid);
        @(posedge clk);
        #1;
        valid_in = valid;
        sof_in   = sof;
        for (int k = 0; k < NCHAN; k++) begin
            data_re_in[k] = f_re(valid ? id : 63, k);
            data_im_in[k] = f_im(valid ? id : 63, k);
            idx_in[k]     = f_idx(valid ? id : 63);
        end
        $display("t=%0t beat id=%0d valid=%0b sof=%0b", $time, id, valid, sof);
    endtask

    task automatic send_pair(int id, bit sof_e, int a_id, int pos);
        exp_t e;
        send(id, 1'b0, 1'b1);
        e.a_id = a_id; e.b_id = id; e.pos = pos; e.sof = sof_e; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            sof_in   = 1'b0;
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_sof"}, 32'(sof_out), 32'd0);
        check({tag, "_pos"}, 32'(pair_pos), 32'd0);
        for (int k = 0; k < NCHAN; k++) begin
            check({tag, "_lane"}, {a_re[k], a_im[k], 3'b0, a_idx[k]}, 32'd0);
            check({tag, "_lane"}, {b_re[k], b_im[k], 3'b0, b_idx[k]}, 32'd0);
        end
    endtask

    // Output monitor: pops the scoreboard on each pair, checks hold otherwise
    always @(negedge clk) begin
        if (rst) begin
            snap_a = -1; snap_b = -1; snap_pos = 0;
        end else if (valid_out) begin
            if (q.size() == 0) begin
                check("unexpected_pair", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("t=%0t pair a=%0d b=%0d pos=%0d sof=%0b", $time, e.a_id, e.b_id, pair_pos, sof_out);
                check("pair_cycle", 32'(cyc), 32'(e.cyc));
                check("pair_pos", 32'(pair_pos), 32'(e.pos));
                check("pair_sof", 32'(sof_out), 32'(e.sof));
                for (int k = 0; k < NCHAN; k++) begin
                    check("a_re", 32'(a_re[k]), 32'(f_re(e.a_id, k)));
                    check("a_im", 32'(a_im[k]), 32'(f_im(e.a_id, k)));
                    check("a_idx", 32'(a_idx[k]), 32'(f_idx(e.a_id)));
                    check("b_re", 32'(b_re[k]), 32'(f_re(e.b_id, k)));
                    check("b_im", 32'(b_im[k]), 32'(f_im(e.b_id, k)));
                    check("b_idx", 32'(b_idx[k]), 32'(f_idx(e.b_id)));
                end
                snap_a = e.a_id; snap_b = e.b_id; snap_pos = e.pos;
            end
        end else begin
            check("idle_sof", 32'(sof_out), 32'd0);
            check("hold_pos", 32'(pair_pos), 32'(snap_pos));
            for (int k = 0; k < NCHAN; k++) begin
                check("hold_a", {a_re[k], a_im[k], 3'b0, a_idx[k]},
                      {f_re(snap_a, k), f_im(snap_a, k), 3'b0, f_idx(snap_a)});
                check("hold_b", {b_re[k], b_im[k], 3'b0, b_idx[k]},
                      {f_re(snap_b, k), f_im(snap_b, k), 3'b0, f_idx(snap_b)});
            end
        end
    end

    initial begin
        for (int k = 0; k < NCHAN; k++) begin
            data_re_in[k] = '0; data_im_in[k] = '0; idx_in[k] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Ramp: 8 consecutive beats, sof on beat 0
        send(0, 1'b1, 1'b1);
        for (int n = 1; n < 4; n++) send(n, 1'b0, 1'b1);
        for (int n = 4; n < 8; n++) send_pair(n, n == 4, n - 4, n - 4);
        idle(3);

        // Gapped: valid toggling, idle cycles carry sof_in=1 that must be ignored
        send(8, 1'b1, 1'b1);
        send(0, 1'b1, 1'b0);
        for (int n = 9; n < 12; n++) begin
            send(n, 1'b0, 1'b1);
            send(0, 1'b1, 1'b0);
        end
        for (int n = 12; n < 16; n++) begin
            send_pair(n, n == 12, n - 4, n - 12);
            send(0, 1'b1, 1'b0);
        end
        idle(3);

        // Resync: second sof on beat 6 abandons the rest of the first group
        send(20, 1'b1, 1'b1);
        for (int n = 21; n < 24; n++) send(n, 1'b0, 1'b1);
        send_pair(24, 1'b1, 20, 0);
        send_pair(25, 1'b0, 21, 1);
        send(26, 1'b1, 1'b1);
        for (int n = 27; n < 30; n++) send(n, 1'b0, 1'b1);
        for (int n = 30; n < 34; n++) send_pair(n, n == 30, n - 4, n - 30);
        idle(3);

        // Reset mid-group after 5 beats, then a fresh unsynchronised stream
        send(40, 1'b1, 1'b1);
        for (int n = 41; n < 44; n++) send(n, 1'b0, 1'b1);
        send_pair(44, 1'b1, 40, 0);
        idle(2);
        #1 rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 50; n < 54; n++) send(n, 1'b0, 1'b1);
        for (int n = 54; n < 58; n++) send_pair(n, 1'b0, n - 4, n - 54);
        idle(3);

        // Extremes, 16 back-to-back beats: two fill/pair bursts across the wrap
        send(100, 1'b1, 1'b1);
        for (int n = 101; n < 104; n++) send(n, 1'b0, 1'b1);
        for (int n = 104; n < 108; n++) send_pair(n, n == 104, n - 4, n - 104);
        for (int n = 108; n < 112; n++) send(n, 1'b0, 1'b1);
        for (int n = 112; n < 116; n++) send_pair(n, 1'b0, n - 4, n - 112);
        idle(4);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
